hw5_seq_checker: RTL and testbench
==================================

// Module: hw5_seq_checker
// PURPOSE
//  Receive-side monitor for the HW5 3-bit sequence generator. Samples o[3:1] every clk,
//  locks onto the LFSR sequence, then flags each sample that breaks it. Sits beside HW5
//  in the bench/top; the generator's set pulse is fed in as a resync hint.
//  Sequence: next = {o[2], o[1], o[3]^o[2]}; period 7:
//  001->010->101->011->111->110->100->001. 3'b000 is illegal (lockup).
// PARAMETERS
//  LOCK_CNT  3  consecutive correct predictions needed to declare lock (1..7)
//  LOSS_CNT  2  consecutive mismatches while locked that drop lock (1..7)
//  ERR_W     8  width of saturating error counter
// PORTS
//  clk       in   1      rising-edge clock, same clock as generator
//  set_n     in   1      async active-low reset
//  seq_set   in   1      generator set/reload pulse; forces reacquire
//  seq_in    in   3      generator output o[3:1], sampled each rising clk
//  locked    out  1      1 while in LOCKED state
//  err       out  1      one-cycle pulse per mismatch detected while LOCKED
//  err_cnt   out  ERR_W  total mismatches while LOCKED, saturates at all-ones
//  exp_out   out  3      predicted value for the next sample (valid when locked)
// BEHAVIOUR
//  Reset (set_n=0, async): state=ACQ, locked=0, err=0, err_cnt=0, exp_out=3'b000,
//   run counter=0, miss counter=0. Release synchronous to next edge is fine; checker
//   does nothing until first edge with set_n=1.
//  All decisions on rising clk using registered prediction exp vs current seq_in.
//  States: ACQ, TRACK, LOCKED.
//   ACQ: if seq_in!=000: exp<=next(seq_in), run<=0, go TRACK. If 000: stay ACQ.
//   TRACK: seq_in==exp -> run+1, exp<=next(seq_in); when run+1==LOCK_CNT go LOCKED.
//          mismatch or 000 -> reseed: exp<=next(seq_in) (if !=000), run<=0, stay TRACK
//          (go ACQ if seq_in==000). No err pulses and no err_cnt change in ACQ/TRACK.
//   LOCKED: match -> miss<=0, exp<=next(exp). Mismatch (incl. 000) -> err=1 for that
//          cycle, err_cnt+1 (sat), miss+1, exp<=next(exp) (flywheel, does not reseed);
//          when miss+1==LOSS_CNT -> go ACQ, locked=0 next cycle.
//  locked is registered: rises the cycle after the LOCK_CNT-th match is seen.
//  Latency: err asserted the cycle after the bad sample is presented (registered).
//  seq_in is taken as the post-reset/post-set value the cycle seq_set is high:
//   seq_set=1 in any state -> go ACQ, run/miss<=0, no err, err_cnt unchanged;
//   seq_set has priority over a same-cycle mismatch.
//  err_cnt wraps never: at 2^ERR_W-1 it holds, err still pulses.
//  exp_out mirrors exp register; 000 in ACQ.
//  Reset mid-lock: all state cleared immediately, err_cnt to 0.
// TESTING
//  1 Reset, drive 001,010,101,011 from cycle 1 -> locked=1 after 3rd correct
//    prediction (sample 011), err never pulses, exp_out=111.
//  2 Locked, inject 000 once then resume correct sequence -> one err pulse,
//    err_cnt=1, locked stays 1 (LOSS_CNT=2), next match clears miss.
//  3 Locked, inject two wrong samples (e.g. 111 instead of 110, then 001 instead of
//    100) -> two err pulses, err_cnt=2, locked=0 the cycle after 2nd error, then
//    relocks after 3 correct predictions from new seed.
//  4 seq_set pulse while locked coincident with wrong sample -> no err, err_cnt
//    unchanged, locked=0, relock on following correct run.
//  5 ERR_W=2, force 5 isolated errors (each followed by matches) -> err_cnt
//    saturates at 3, err pulses 5 times.
//  6 Assert set_n=0 mid-LOCKED between clock edges -> locked, err, err_cnt, exp_out
//    go 0 immediately without a clock edge.

Source files
------------

// File: rtl/hw5_seq_checker.sv
// hw5_seq_checker: locks onto the HW5 3-bit LFSR sequence and flags samples that break it.
//  clk      rising-edge clock shared with the generator
//  set_n    async active-low reset
//  seq_set  generator reload pulse, forces reacquire
//  seq_in   generator output o[3:1]
//  locked   high while locked
//  err      one-cycle pulse per mismatch seen while locked
//  err_cnt  saturating count of mismatches seen while locked
//  exp_out  predicted next sample, 000 while acquiring
module hw5_seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             set_n,
  input  logic             seq_set,
  input  logic [2:0]       seq_in,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       exp_out
);
  typedef enum logic [1:0] {S_ACQ, S_TRACK, S_LOCKED} state_t;
  state_t state;
  logic [2:0] run, miss;
  function automatic logic [2:0] nxt(input logic [2:0] v);
    return {v[1], v[0], v[2] ^ v[1]};
  endfunction
  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      state   <= S_ACQ;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      exp_out <= 3'b000;
      run     <= 3'd0;
      miss    <= 3'd0;
    end else begin
      err <= 1'b0;
      if (seq_set) begin
        state   <= S_ACQ;
        locked  <= 1'b0;
        exp_out <= 3'b000;
        run     <= 3'd0;
        miss    <= 3'd0;
      end else begin
        case (state)
          S_ACQ:
            if (seq_in != 3'b000) begin
              exp_out <= nxt(seq_in);
              run     <= 3'd0;
              state   <= S_TRACK;
            end
          S_TRACK:
            if (seq_in == 3'b000) begin
              state   <= S_ACQ;
              exp_out <= 3'b000;
              run     <= 3'd0;
            end else if (seq_in == exp_out) begin
              exp_out <= nxt(seq_in);
              if (run == 3'(LOCK_CNT - 1)) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
                run    <= 3'd0;
                miss   <= 3'd0;
              end else begin
                run <= run + 3'd1;
              end
            end else begin
              exp_out <= nxt(seq_in);
              run     <= 3'd0;
            end
          S_LOCKED:
            if (seq_in == exp_out) begin
              miss    <= 3'd0;
              exp_out <= nxt(exp_out);
            end else begin
              // flywheel: keep predicting from our own sequence rather than reseeding
              err     <= 1'b1;
              err_cnt <= (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
              if (miss == 3'(LOSS_CNT - 1)) begin
                state   <= S_ACQ;
                locked  <= 1'b0;
                miss    <= 3'd0;
                exp_out <= 3'b000;
              end else begin
                miss    <= miss + 3'd1;
                exp_out <= nxt(exp_out);
              end
            end
          default: state <= S_ACQ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hw5_seq_checker.sv
// tb_hw5_seq_checker: vector table, corner sequences and random run against a sequence model.
module tb_hw5_seq_checker;
  localparam int LOCK = 3;
  localparam int LOSS = 2;
  typedef struct {
    logic       s;
    logic [2:0] in;
    logic       lk;
    logic       er;
    int         cnt;
    logic [2:0] ex;
  } vec_t;
  logic clk = 1'b0;
  logic set_n, seq_set;
  logic [2:0] seq_in, exp_out, exp_out2;
  logic locked, err, locked2, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  int checks = 0, errors = 0;
  int seqtab[7] = '{1, 2, 5, 3, 7, 6, 4};
  int m_lock, m_acq, m_run, m_miss, m_exp, m_err, m_errs;
  vec_t tbl[$];
  always #5 clk = ~clk;
  hw5_seq_checker dut (
    .clk(clk), .set_n(set_n), .seq_set(seq_set), .seq_in(seq_in),
    .locked(locked), .err(err), .err_cnt(err_cnt), .exp_out(exp_out)
  );
  hw5_seq_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .set_n(set_n), .seq_set(seq_set), .seq_in(seq_in),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2), .exp_out(exp_out2)
  );
  function automatic int nx(input int v);
    for (int i = 0; i < 7; i++) if (seqtab[i] == v) return seqtab[(i + 1) % 7];
    return 0;
  endfunction
  function automatic vec_t mk(input logic s, input logic [2:0] in, input logic lk,
                              input logic er, input int cnt, input logic [2:0] ex);
    vec_t v;
    v.s = s; v.in = in; v.lk = lk; v.er = er; v.cnt = cnt; v.ex = ex;
    return v;
  endfunction
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic m_reset();
    m_lock = 0; m_acq = 1; m_run = 0; m_miss = 0; m_exp = 0; m_err = 0; m_errs = 0;
  endtask
  task automatic m_step(input int st, input int s);
    m_err = 0;
    if (st != 0) begin
      m_acq = 1; m_lock = 0; m_run = 0; m_miss = 0; m_exp = 0;
    end else if (m_lock != 0) begin
      if (s == m_exp) begin
        m_miss = 0; m_exp = nx(m_exp);
      end else begin
        m_err = 1; m_errs++; m_miss++;
        if (m_miss == LOSS) begin
          m_lock = 0; m_acq = 1; m_miss = 0; m_exp = 0;
        end else m_exp = nx(m_exp);
      end
    end else if (m_acq != 0) begin
      if (s != 0) begin m_exp = nx(s); m_run = 0; m_acq = 0; end
    end else if (s == 0) begin
      m_acq = 1; m_exp = 0; m_run = 0;
    end else if (s == m_exp) begin
      m_run++; m_exp = nx(s);
      if (m_run == LOCK) begin m_lock = 1; m_run = 0; m_miss = 0; end
    end else begin
      m_exp = nx(s); m_run = 0;
    end
  endtask
  task automatic cyc(input logic st, input logic [2:0] s);
    seq_set = st;
    seq_in = s;
    @(posedge clk);
    m_step(int'(st), int'(s));
    #1;
    chk("locked", locked, m_lock);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_errs > 255 ? 255 : m_errs);
    chk("exp_out", exp_out, m_exp);
    chk("locked_w2", locked2, m_lock);
    chk("err_w2", err2, m_err);
    chk("err_cnt_w2", err_cnt2, m_errs > 3 ? 3 : m_errs);
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_exp_out"}, exp_out, 0);
    chk({tag, "_err_cnt_w2"}, err_cnt2, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int r, pulses;
    logic st;
    logic [2:0] v;
    set_n = 1'b0;
    seq_set = 1'b0;
    seq_in = 3'b000;
    m_reset();
    #2;
    zero_chk("reset");
    #10;
    set_n = 1'b1;
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000));
    tbl.push_back(mk(0, 3'b001, 0, 0, 0, 3'b010));
    tbl.push_back(mk(0, 3'b010, 0, 0, 0, 3'b101));
    tbl.push_back(mk(0, 3'b101, 0, 0, 0, 3'b011));
    tbl.push_back(mk(0, 3'b011, 1, 0, 0, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 1, 1, 3'b110));
    tbl.push_back(mk(0, 3'b110, 1, 0, 1, 3'b100));
    tbl.push_back(mk(0, 3'b100, 1, 0, 1, 3'b001));
    tbl.push_back(mk(0, 3'b111, 1, 1, 2, 3'b010));
    tbl.push_back(mk(0, 3'b010, 1, 0, 2, 3'b101));
    tbl.push_back(mk(0, 3'b000, 1, 1, 3, 3'b011));
    tbl.push_back(mk(0, 3'b011, 1, 0, 3, 3'b111));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3, 3'b110));
    tbl.push_back(mk(0, 3'b111, 1, 1, 4, 3'b100));
    tbl.push_back(mk(0, 3'b001, 0, 1, 5, 3'b000));
    tbl.push_back(mk(0, 3'b101, 0, 0, 5, 3'b011));
    tbl.push_back(mk(0, 3'b110, 0, 0, 5, 3'b100));
    tbl.push_back(mk(0, 3'b100, 0, 0, 5, 3'b001));
    tbl.push_back(mk(0, 3'b001, 0, 0, 5, 3'b010));
    tbl.push_back(mk(0, 3'b010, 1, 0, 5, 3'b101));
    tbl.push_back(mk(1, 3'b111, 0, 0, 5, 3'b000));
    tbl.push_back(mk(0, 3'b001, 0, 0, 5, 3'b010));
    tbl.push_back(mk(0, 3'b010, 0, 0, 5, 3'b101));
    tbl.push_back(mk(0, 3'b101, 0, 0, 5, 3'b011));
    tbl.push_back(mk(0, 3'b011, 1, 0, 5, 3'b111));
    tbl.push_back(mk(1, 3'b001, 0, 0, 5, 3'b000));
    tbl.push_back(mk(0, 3'b001, 0, 0, 5, 3'b010));
    tbl.push_back(mk(0, 3'b000, 0, 0, 5, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 0, 5, 3'b000));
    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].in);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
      chk($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_exp_out", i), exp_out, tbl[i].ex);
      chk($sformatf("tbl%0d_err_cnt_w2", i), err_cnt2, tbl[i].cnt > 3 ? 3 : tbl[i].cnt);
    end
    #3 set_n = 1'b0;
    m_reset();
    #2 set_n = 1'b1;
    cyc(0, 3'b001); cyc(0, 3'b010); cyc(0, 3'b101); cyc(0, 3'b011);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 3'b000);
      if (err2) pulses++;
      cyc(0, 3'(m_exp));
      cyc(0, 3'(m_exp));
    end
    chk("sat_pulses", pulses, 5);
    chk("sat_cnt_w2", err_cnt2, 3);
    chk("sat_cnt_w8", err_cnt, 5);
    chk("sat_locked", locked2, 1);
    cyc(0, 3'b000);
    chk("pre_async_err", err, 1);
    #3 set_n = 1'b0;
    #1;
    zero_chk("async");
    m_reset();
    #2 set_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99);
      st = ($urandom_range(39) == 0);
      v = (r < 70 && m_exp != 0) ? 3'(m_exp) : (r < 80) ? 3'b000 : 3'($urandom_range(7));
      cyc(st, v);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
